// File: rtl/riscv_pkg.sv
// Shared load/store definitions: funct3 access encodings, LSU FSM states and the default
// memory timeout.
package riscv_pkg;

   localparam logic [2:0] F3Byte  = 3'b000;
   localparam logic [2:0] F3Half  = 3'b001;
   localparam logic [2:0] F3Word  = 3'b010;
   localparam logic [2:0] F3ByteU = 3'b100;
   localparam logic [2:0] F3HalfU = 3'b101;

   localparam int unsigned LsuTimeoutDefault = 64;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DONE
   } lsu_state_t;

   function automatic logic f3_legal(input logic [2:0] f3);
      return f3 inside {F3Byte, F3Half, F3Word, F3ByteU, F3HalfU};
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory request/acknowledge bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if;

   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic        ack;
   logic [31:0] rdata;

   modport master (output req, we, addr, wdata, be, input ack, rdata);
   modport slave  (input req, we, addr, wdata, be, output ack, rdata);

endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables and replicated write data, plus load lane
// selection with sign or zero extension.
module lsu_align
   import riscv_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  offset_i,
   input  logic [31:0] store_data_i,
   input  logic [31:0] load_word_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] load_data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic        is_unsigned;

   assign is_unsigned = funct3_i[2];
   assign half_sel    = offset_i[1] ? load_word_i[31:16] : load_word_i[15:0];

   always_comb begin
      byte_sel = load_word_i[7:0];
      case (offset_i)
         2'd1:    byte_sel = load_word_i[15:8];
         2'd2:    byte_sel = load_word_i[23:16];
         2'd3:    byte_sel = load_word_i[31:24];
         default: byte_sel = load_word_i[7:0];
      endcase
   end

   always_comb begin
      be_o        = 4'b1111;
      wdata_o     = store_data_i;
      load_data_o = load_word_i;
      case (funct3_i[1:0])
         2'b00: begin
            be_o        = 4'b0001 << offset_i;
            wdata_o     = {4{store_data_i[7:0]}};
            load_data_o = {{24{byte_sel[7] & ~is_unsigned}}, byte_sel};
         end
         2'b01: begin
            be_o        = offset_i[1] ? 4'b1100 : 4'b0011;
            wdata_o     = {2{store_data_i[15:0]}};
            load_data_o = {{16{half_sel[15] & ~is_unsigned}}, half_sel};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: captures the access, runs a req/ack memory transaction with timeout and
// stalls the core until done. Define LSU_MISALIGN_TRAP_EN to reject misaligned H/HU/W accesses.
module load_store_unit
   import riscv_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = LsuTimeoutDefault
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      MemRead,
   input  logic                      MemWrite,
   input  logic [2:0]                funct3,
   input  logic [31:0]               ALU_result,
   input  logic [31:0]               Read_data2,
   output logic [31:0]               Read_data,
   output logic                      stall,
   output logic                      lsu_error,
   load_store_unit_if.master         mem
);

   localparam int unsigned     CntW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   lsu_state_t      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [31:0]     addr_q, addr_d;
   logic [2:0]      f3_q, f3_d;
   logic [31:0]     sdata_q, sdata_d;
   logic            we_q, we_d;
   logic [31:0]     rd_q, rd_d;
   logic            err_q, err_d;

   logic            access;
   logic            legal;
   logic [31:0]     addr_aligned;
   logic [3:0]      align_be;
   logic [31:0]     align_wdata;
   logic [31:0]     align_load;

   assign access = MemRead | MemWrite;

   always_comb begin
      case (funct3[1:0])
         2'b01:   addr_aligned = {ALU_result[31:1], 1'b0};
         2'b10:   addr_aligned = {ALU_result[31:2], 2'b00};
         default: addr_aligned = ALU_result;
      endcase
   end

`ifdef LSU_MISALIGN_TRAP_EN
   logic misaligned;
   assign misaligned = ((funct3[1:0] == 2'b01) & ALU_result[0]) |
                       ((funct3[1:0] == 2'b10) & (|ALU_result[1:0]));
   assign legal = f3_legal(funct3) & ~misaligned;
`else
   assign legal = f3_legal(funct3);
`endif

   lsu_align u_align (
      .funct3_i     (f3_q),
      .offset_i     (addr_q[1:0]),
      .store_data_i (sdata_q),
      .load_word_i  (mem.rdata),
      .be_o         (align_be),
      .wdata_o      (align_wdata),
      .load_data_o  (align_load)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      f3_d    = f3_q;
      sdata_d = sdata_q;
      we_d    = we_q;
      rd_d    = rd_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (access) begin
               addr_d  = addr_aligned;
               f3_d    = funct3;
               sdata_d = Read_data2;
               we_d    = MemWrite;
               if (legal) begin
                  state_d = REQ;
                  cnt_d   = '0;
               end else begin
                  state_d = DONE;
                  err_d   = 1'b1;
               end
            end
         end
         REQ: begin
            // An ack in the final allowed cycle takes priority over the abort.
            if (mem.ack) begin
               if (!we_q) rd_d = align_load;
               state_d = DONE;
            end else if (cnt_q == CntLast) begin
               rd_d    = '0;
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         f3_q    <= '0;
         sdata_q <= '0;
         we_q    <= 1'b0;
         rd_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         f3_q    <= f3_d;
         sdata_q <= sdata_d;
         we_q    <= we_d;
         rd_q    <= rd_d;
         err_q   <= err_d;
      end
   end

   // Reset gating keeps stall low while reset is held even if MemRead/MemWrite are high.
   assign stall     = reset & (((state_q == IDLE) & access) | (state_q == REQ));
   assign Read_data = rd_q;
   assign lsu_error = err_q;
   assign mem.req   = (state_q == REQ);
   assign mem.we    = we_q;
   assign mem.addr  = {addr_q[31:2], 2'b00};
   assign mem.wdata = align_wdata;
   assign mem.be    = we_q ? align_be : 4'b0000;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: hand-computed vector table, randomized accesses against a
// reference model, and reset corner cases.
module tb_load_store_unit;

   localparam int TO = 64;

   logic        clock;
   logic        reset;
   logic        MemRead;
   logic        MemWrite;
   logic [2:0]  funct3;
   logic [31:0] ALU_result;
   logic [31:0] Read_data2;
   logic [31:0] Read_data;
   logic        stall;
   logic        lsu_error;

   load_store_unit_if mem_bus ();

   load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
      .clock      (clock),
      .reset      (reset),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .funct3     (funct3),
      .ALU_result (ALU_result),
      .Read_data2 (Read_data2),
      .Read_data  (Read_data),
      .stall      (stall),
      .lsu_error  (lsu_error),
      .mem        (mem_bus.master)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rdata;
      int          ack_at;
      logic [31:0] exp_rd;
      logic [31:0] exp_addr;
      logic [31:0] exp_wdata;
      logic [3:0]  exp_be;
      logic        exp_we;
      int          exp_stall;
      int          exp_req;
      int          exp_err;
   } vec_t;

   typedef struct {
      int          stall_cycles;
      int          req_cycles;
      int          err_pulses;
      logic [31:0] rd;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        we;
      logic        finished;
      logic        post_req;
      logic        post_stall;
   } obs_t;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] model_rd = 32'h0;
   vec_t        vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   // Reference: derived from access size, lane offset and timeout rules in plain arithmetic.
   function automatic vec_t model_vec(input logic rd, input logic wr, input logic [2:0] f3,
                                      input logic [31:0] a, input logic [31:0] wd,
                                      input logic [31:0] rdw, input int ack_at,
                                      input logic [31:0] prev_rd);
      vec_t        v;
      int unsigned size;
      logic [31:0] ea;
      logic [31:0] val;
      bit          legal;
      v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.wd = wd; v.rdata = rdw;
      v.ack_at = ack_at;
      size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      legal = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
`ifdef LSU_MISALIGN_TRAP_EN
      if ((a % size) != 0) legal = 0;
`endif
      ea = a - (a % size);
      v.exp_addr  = ea - (ea % 4);
      v.exp_we    = wr;
      v.exp_be    = wr ? 4'(((1 << size) - 1) << (ea % 4)) : 4'h0;
      v.exp_wdata = (size == 1) ? wd[7:0] * 32'h01010101 :
                    (size == 2) ? wd[15:0] * 32'h00010001 : wd;
      val = rdw >> (8 * (ea % 4));
      if (size < 4) begin
         val = val % (32'd1 << (8 * size));
         if (!f3[2] && val >= (32'd1 << (8 * size - 1))) val = val - (32'd1 << (8 * size));
      end
      if (!legal) begin
         v.exp_stall = 1; v.exp_req = 0; v.exp_err = 1; v.exp_rd = prev_rd;
      end else if (ack_at < 1 || ack_at > TO) begin
         v.exp_stall = 1 + TO; v.exp_req = TO; v.exp_err = 1; v.exp_rd = 32'h0;
      end else begin
         v.exp_stall = 1 + ack_at; v.exp_req = ack_at; v.exp_err = 0;
         v.exp_rd = wr ? prev_rd : val;
      end
      return v;
   endfunction

   task automatic run_access(input vec_t v, output obs_t o);
      o = '{default: 0};
      @(posedge clock); #1;
      MemRead = v.rd; MemWrite = v.wr; funct3 = v.f3; ALU_result = v.addr;
      Read_data2 = v.wd; mem_bus.rdata = v.rdata; mem_bus.ack = 1'b0;
      for (int n = 0; n < 300 && !o.finished; n++) begin
         @(negedge clock);
         if (lsu_error) o.err_pulses++;
         if (mem_bus.req) begin
            o.req_cycles++;
            o.addr = mem_bus.addr; o.be = mem_bus.be; o.we = mem_bus.we;
            o.wdata = mem_bus.wdata;
            mem_bus.ack = (o.req_cycles == v.ack_at);
         end else begin
            mem_bus.ack = 1'b0;
         end
         if (stall) o.stall_cycles++;
         else begin
            o.rd = Read_data;
            o.finished = 1'b1;
         end
      end
      @(posedge clock); #1;
      MemRead = 1'b0; MemWrite = 1'b0; mem_bus.ack = 1'b0;
      @(negedge clock);
      if (lsu_error) o.err_pulses++;
      o.post_req = mem_bus.req;
      o.post_stall = stall;
   endtask

   task automatic apply_vec(input vec_t v, input string tag);
      obs_t o;
      run_access(v, o);
      chk({tag, ".finished"}, 32'(o.finished), 32'd1);
      chk({tag, ".stall_cycles"}, o.stall_cycles, v.exp_stall);
      chk({tag, ".req_cycles"}, o.req_cycles, v.exp_req);
      chk({tag, ".err_pulses"}, o.err_pulses, v.exp_err);
      chk({tag, ".read_data"}, o.rd, v.exp_rd);
      chk({tag, ".no_retrigger"}, {30'd0, o.post_req, o.post_stall}, 32'd0);
      if (v.exp_req > 0) begin
         chk({tag, ".mem_addr"}, o.addr, v.exp_addr);
         chk({tag, ".mem_be"}, 32'(o.be), 32'(v.exp_be));
         chk({tag, ".mem_we"}, 32'(o.we), 32'(v.exp_we));
         if (v.exp_we) chk({tag, ".mem_wdata"}, o.wdata, v.exp_wdata);
      end
      model_rd = v.exp_rd;
   endtask

   initial begin
      logic [31:0] rd10;
      vec_t        rv;

      reset = 1'b0; MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010;
      ALU_result = 32'h100; Read_data2 = 32'h0; mem_bus.ack = 1'b0; mem_bus.rdata = 32'h0;
      #12;
      chk("reset.read_data", Read_data, 32'h0);
      chk("reset.stall", 32'(stall), 32'h0);
      chk("reset.lsu_error", 32'(lsu_error), 32'h0);
      chk("reset.mem_req", 32'(mem_bus.req), 32'h0);
      chk("reset.mem_we", 32'(mem_bus.we), 32'h0);
      chk("reset.mem_addr", mem_bus.addr, 32'h0);
      chk("reset.mem_wdata", mem_bus.wdata, 32'h0);
      chk("reset.mem_be", 32'(mem_bus.be), 32'h0);
      MemRead = 1'b0;
      @(negedge clock); reset = 1'b1;

`ifdef LSU_MISALIGN_TRAP_EN
      vecs[9] = '{1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'h11223344, 1,
                  32'h0000F00D, 32'h0, 32'h0, 4'h0, 1'b0, 1, 0, 1};
      rd10 = 32'h0000F00D;
`else
      vecs[9] = '{1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'h11223344, 1,
                  32'h11223344, 32'h100, 32'h0, 4'h0, 1'b0, 2, 1, 0};
      rd10 = 32'h11223344;
`endif
      vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2,
                   32'hDEADBEEF, 32'h100, 32'h0, 4'h0, 1'b0, 3, 2, 0};
      vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80123456, 1,
                   32'hFFFFFF80, 32'h100, 32'h0, 4'h0, 1'b0, 2, 1, 0};
      vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80123456, 1,
                   32'h00000080, 32'h100, 32'h0, 4'h0, 1'b0, 2, 1, 0};
      vecs[3]  = '{1'b0, 1'b1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 1,
                   32'h00000080, 32'h100, 32'hABCDABCD, 4'hC, 1'b1, 2, 1, 0};
      vecs[4]  = '{1'b0, 1'b1, 3'b000, 32'h101, 32'h123456A5, 32'h0, 3,
                   32'h00000080, 32'h100, 32'hA5A5A5A5, 4'h2, 1'b1, 4, 3, 0};
      vecs[5]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80017FFF, 1,
                   32'hFFFF8001, 32'h100, 32'h0, 4'h0, 1'b0, 2, 1, 0};
      vecs[6]  = '{1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 32'h1234F00D, 1,
                   32'h0000F00D, 32'h100, 32'h0, 4'h0, 1'b0, 2, 1, 0};
      vecs[7]  = '{1'b1, 1'b1, 3'b010, 32'h104, 32'hCAFEF00D, 32'h0, 2,
                   32'h0000F00D, 32'h104, 32'hCAFEF00D, 4'hF, 1'b1, 3, 2, 0};
      vecs[8]  = '{1'b1, 1'b0, 3'b011, 32'h200, 32'h0, 32'h0, 1,
                   32'h0000F00D, 32'h0, 32'h0, 4'h0, 1'b0, 1, 0, 1};
      vecs[10] = '{1'b0, 1'b1, 3'b111, 32'h300, 32'h55, 32'h0, 1,
                   rd10, 32'h0, 32'h0, 4'h0, 1'b1, 1, 0, 1};
      vecs[11] = '{1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 32'h12345678, 0,
                   32'h0, 32'h400, 32'h0, 4'h0, 1'b0, 65, 64, 1};
      vecs[12] = '{1'b1, 1'b0, 3'b010, 32'h404, 32'h0, 32'h5A5A0001, 64,
                   32'h5A5A0001, 32'h404, 32'h0, 4'h0, 1'b0, 65, 64, 0};

      for (int i = 0; i < 13; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

      for (int i = 0; i < 120; i++) begin
         int unsigned op;
         int          ack;
         op  = $urandom_range(2, 0);
         ack = ($urandom_range(15, 0) == 0) ? 0 : int'($urandom_range(4, 1));
         rv  = model_vec(op != 1, op != 0, 3'($urandom_range(7, 0)), $urandom, $urandom,
                         $urandom, ack, model_rd);
         apply_vec(rv, $sformatf("rand%0d", i));
      end

      // Reset while a request is outstanding, then a late ack.
      @(posedge clock); #1;
      MemRead = 1'b1; funct3 = 3'b010; ALU_result = 32'h0000_0ABC; mem_bus.ack = 1'b0;
      @(negedge clock);
      @(negedge clock);
      chk("midreset.req_before", 32'(mem_bus.req), 32'd1);
      #1 reset = 1'b0;
      #1;
      chk("midreset.mem_req", 32'(mem_bus.req), 32'd0);
      chk("midreset.stall", 32'(stall), 32'd0);
      chk("midreset.mem_addr", mem_bus.addr, 32'd0);
      chk("midreset.read_data", Read_data, 32'd0);
      MemRead = 1'b0; mem_bus.ack = 1'b1; mem_bus.rdata = 32'hFFFF_FFFF;
      @(posedge clock); #1; mem_bus.ack = 1'b0;
      @(negedge clock); reset = 1'b1;
      model_rd = 32'h0;
      @(negedge clock);
      chk("postreset.mem_req", 32'(mem_bus.req), 32'd0);
      chk("postreset.stall", 32'(stall), 32'd0);
      chk("postreset.read_data", Read_data, 32'd0);
      rv = model_vec(1'b1, 1'b0, 3'b010, 32'h0000_0ABC, 32'h0, 32'h0BADF00D, 1, model_rd);
      apply_vec(rv, "postreset.lw");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the single-cycle RISC-V core datapath and data memory. It takes the ALU result as the effective address and the second register read port as store data, then runs a req/ack transaction to memory. It returns the sign/zero-extended load value to the write-back mux, and holds the core (PC and register file) with `stall` until the access completes.

## Interface
- `TIMEOUT_CYCLES`, default 64: max cycles in REQ without `mem_ack` before the access is aborted with an error.
- `clock`  in  1  core clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `MemRead`  in  1  instruction is a load.
- `MemWrite`  in  1  instruction is a store; wins over `MemRead` if both are high.
- `funct3`  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `ALU_result`  in  32  effective byte address.
- `Read_data2`  in  32  store data.
- `Read_data`  out  32  extended load value, registered.
- `stall`  out  1  high means the core must not advance PC or write registers.
- `lsu_error`  out  1  one-cycle pulse in DONE for an aborted or illegal access.
- `mem_req`  out  1  request, held until acknowledged.
- `mem_we`  out  1  1 means write.
- `mem_addr`  out  32  word-aligned address (`[1:0]` = 0).
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_be`  out  4  byte enables; 0000 on reads.
- `mem_ack`  in  1  one-cycle completion; sampled only while `mem_req` = 1.
- `mem_rdata`  in  32  read word; valid in the `mem_ack` cycle.

## Operation
- FSM states: IDLE, REQ, DONE.
- **IDLE**
  - If `MemRead|MemWrite`, capture address, `funct3`, store data and `we`.
  - Legal access: go to REQ.
  - Illegal `funct3` (011, 110, 111): go directly to DONE with error.
- **REQ**
  - `mem_req` = 1; `mem_addr`, `mem_we`, `mem_be` and `mem_wdata` are stable from the captured values.
  - On `mem_ack`: for loads, register the extended `mem_rdata` into `Read_data`; go to DONE.
  - On timeout: drop `mem_req`, set `Read_data` = 0, go to DONE with error.
- **DONE**
  - Stays one cycle; `stall` = 0 so the core commits on the closing edge.
  - Does not re-trigger on the still-asserted `MemRead`/`MemWrite`; next state is IDLE.
- `stall` = (IDLE & (`MemRead`|`MemWrite`)) | REQ. It is combinational so the core freezes in the capture cycle.
- Store lanes:
  - SB: `be` = 0001 << `addr[1:0]`, `wdata` = {4{`Read_data2[7:0]`}}.
  - SH: `be` = `addr[1]` ? 1100 : 0011, `wdata` = {2{`Read_data2[15:0]`}}.
  - SW: `be` = 1111, `wdata` = `Read_data2`.
- Loads select the byte/half by `addr[1:0]`/`addr[1]`. B/H sign-extend; BU/HU zero-extend.
- `Read_data` holds its value until the next completed load; stores do not modify it.

## Timing
- Reset: state IDLE, timeout counter 0, and every output 0 (`Read_data`, `stall`, `lsu_error`, `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`). Reset asserted mid-transaction drops `mem_req` immediately; any late `mem_ack` is ignored.
- Zero-wait memory (ack in the first REQ cycle): the access takes 3 cycles (IDLE capture, REQ, DONE) and `stall` is high for exactly 2 cycles.
- Each extra wait cycle adds 1 cycle of stall.
- Timeout counter:
  - Clears on entry to REQ and increments each REQ cycle without ack.
  - Aborts when it reaches `TIMEOUT_CYCLES`.
  - An ack arriving in that same cycle wins and the access completes normally.
- Error path: no `mem_req` is issued and `stall` is high for 1 cycle.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: an H/HU access with `addr[0]` = 1, or a W access with `addr[1:0]` ≠ 0, is treated as illegal. It issues no request and pulses `lsu_error` in DONE.
- `LSU_MISALIGN_TRAP_EN` undefined: address bits below the access size are forced to 0 and the access proceeds aligned without error.

## Structure
- The shared package `riscv_pkg` holds:
  - the `funct3` load/store encodings as constants;
  - the `lsu_state_t` enum (IDLE, REQ, DONE);
  - the default timeout constant.
- One combinational sub-module, `lsu_align`, computes store lane steering and byte enables, plus load lane selection and extension. The FSM, timeout counter and capture registers stay in `load_store_unit`.

## Test plan
- LW at 0x100, ack 1 cycle after req with `mem_rdata` = 0xDEADBEEF -> `Read_data` = 0xDEADBEEF in DONE; `stall` high for 3 cycles.
- LB at 0x103 with `mem_rdata` = 0x80123456 -> `Read_data` = 0xFFFFFF80; LBU at the same address -> 0x00000080.
- SH at 0x102 with `Read_data2` = 0x0000ABCD -> `mem_we` = 1, `mem_addr` = 0x100, `mem_be` = 1100, `mem_wdata` = 0xABCDABCD; `Read_data` unchanged.
- Ack withheld with `TIMEOUT_CYCLES` = 64 -> `mem_req` falls after 64 REQ cycles, `lsu_error` pulses once, `Read_data` = 0. Repeat with ack on exactly cycle 64 -> normal completion, no error.
- LW at 0x102 -> with the macro: no `mem_req`, `lsu_error` = 1, `stall` for 1 cycle. Without the macro: `mem_addr` = 0x100, `mem_be` = 0000, read completes.
- `reset` low while `mem_req` = 1 -> `mem_req`, `stall` and `mem_addr` go to 0 immediately. After release, a new LW runs normally.
